zkey_multi_debounce_edge: RTL and testbench
===========================================

# zkey_multi_debounce_edge

Parametrised successor to the single-key edge detector. Synchronises, debounces and edge-detects `CHANNELS` independent active-low mechanical key inputs. Per channel it produces a clean debounced level, one-cycle press and release pulses, and an optional long-press pulse. It sits between the FPGA key pins and the front-panel/mode-control logic of the photon counter.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent key inputs (1..32).
- `SYNC_STAGES`, 2: flip-flops in each input synchroniser (2..4).
- `DEBOUNCE_CYCLES`, 20000: consecutive stable cycles required to accept a level change (≥2).
- `LONG_PRESS_CYCLES`, 2000000: cycles a key must stay debounced-low before `long_press` fires. Used only with `ZKEY_LONG_PRESS_EN`.

Ports:
- `clk`, in, 1: single system clock; all logic on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `key_pin`, in, `CHANNELS`: raw asynchronous key inputs; idle high, pressed low.
- `key_state`, out, `CHANNELS`: debounced level per channel.
- `h2l_edge`, out, `CHANNELS`: one-cycle pulse on an accepted press (1→0).
- `l2h_edge`, out, `CHANNELS`: one-cycle pulse on an accepted release (0→1).
- `long_press`, out, `CHANNELS`: one-cycle pulse on an accepted long press.

## Operation
- Channels are fully independent. No arbitration; any number of channels may pulse in the same cycle.
- Synchroniser: a `SYNC_STAGES`-deep shift register per channel. All stages reset to 1 (idle level). The last stage is `sync_in`.
- Per-channel FSM:
  - States: `ST_HIGH` (stable high), `ST_FALL` (candidate low), `ST_LOW` (stable low), `ST_RISE` (candidate high). Reset state is `ST_HIGH`.
  - `ST_HIGH`: if `sync_in`=0, go to `ST_FALL`; counter = 1.
  - `ST_FALL`:
    - If `sync_in`=1, return to `ST_HIGH` and clear the counter. Any glitch shorter than the window is fully discarded.
    - Else, if counter = `DEBOUNCE_CYCLES`-1, go to `ST_LOW` and assert `h2l_edge` for one cycle.
    - Else, increment the counter.
  - `ST_LOW` and `ST_RISE` mirror the above with polarities swapped; the accepted transition asserts `l2h_edge`.
- Debounce counter width is `$clog2(DEBOUNCE_CYCLES)`, one counter per channel. It never wraps, because it is cleared or compared before overflow.
- `key_state` is 1 in `ST_HIGH`/`ST_FALL` and 0 in `ST_LOW`/`ST_RISE`. It changes in the same cycle the corresponding edge pulse is asserted.
- `h2l_edge` and `l2h_edge` of one channel are never asserted together.

## Timing
- Reset values: `key_state` = all ones; `h2l_edge`, `l2h_edge` and `long_press` = all zeros; counters 0; FSMs in `ST_HIGH`.
- All outputs are registered.
- Latency: a clean step on `key_pin` produces its edge pulse exactly `SYNC_STAGES + DEBOUNCE_CYCLES` clocks after the first rising edge that samples the new level.
- Minimum spacing between accepted edges on one channel is `DEBOUNCE_CYCLES` cycles.
- Reset mid-debounce: the counter is discarded and the FSM returns to `ST_HIGH` the next cycle. A key held low through reset is re-accepted with full latency and generates an `h2l_edge`.
- Pulse width is exactly one cycle regardless of how long the key is held.

## Configuration
- Macro: `ZKEY_LONG_PRESS_EN`.
- Defined:
  - Each channel has a saturating hold counter of width `$clog2(LONG_PRESS_CYCLES)+1`, cleared whenever the FSM is not in `ST_LOW`/`ST_RISE`.
  - `long_press` pulses once when the counter reaches `LONG_PRESS_CYCLES`-1; the counter then saturates until release.
  - Leaving `ST_LOW` for `ST_RISE` and back does not clear it.
- Undefined: the `long_press` port remains, tied to 0. No hold counters are synthesised.

## Structure
- Package `zkey_pkg`: FSM state encoding (2-bit localparams `ST_HIGH`=0, `ST_FALL`=1, `ST_LOW`=2, `ST_RISE`=3) and `KEY_IDLE_LEVEL`=1'b1.
- Sub-module `zkey_debounce_chan`: one channel (synchroniser, FSM, counters). The top instantiates `CHANNELS` copies in a generate loop and only concatenates outputs.

## Test plan
Bench parameters: `CHANNELS`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=8, `LONG_PRESS_CYCLES`=32.
- Reset, all pins high for 20 cycles: `key_state`=4'hF, no pulses.
- Clean press on ch0 → `h2l_edge[0]` is a single pulse exactly 10 cycles later, and `key_state[0]`→0 in that same cycle. Release after 20 cycles → `l2h_edge[0]` is a single pulse 10 cycles after release.
- ch1 bounce: low 5 cycles, high 1, low 3, high → no pulses, `key_state[1]` stays 1. Then low held → `h2l_edge[1]` 10 cycles after the last falling transition.
- ch2 and ch3 pressed in the same cycle → both `h2l_edge` bits pulse in the same cycle. ch0 is undisturbed.
- `rst` asserted 4 cycles into a ch0 debounce, key held low → no pulse during reset. `h2l_edge[0]` fires 10 cycles after `rst` deasserts.
- With `ZKEY_LONG_PRESS_EN`, ch0 held low 60 cycles → exactly one `long_press[0]` pulse, 32 cycles after `h2l_edge[0]`. Without the macro, `long_press` stays 0.

Source files
------------

// File: rtl/zkey_pkg.sv
// Shared definitions for the multi-channel key debouncer: FSM state encoding
// and the idle (released) level of a key pin.
package zkey_pkg;

  typedef enum logic [1:0] {
    ST_HIGH = 2'd0,
    ST_FALL = 2'd1,
    ST_LOW  = 2'd2,
    ST_RISE = 2'd3
  } zkey_state_t;

  localparam logic KEY_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/zkey_debounce_chan.sv
// One key channel: synchroniser, debounce FSM with counter and registered outputs.
// Optional long-press detection is built only when ZKEY_LONG_PRESS_EN is defined.
module zkey_debounce_chan
  import zkey_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 20000,
  parameter int LONG_PRESS_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_pin,
  output logic key_state,
  output logic h2l_edge,
  output logic l2h_edge,
  output logic long_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_param
    $error("zkey_debounce_chan: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  zkey_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic                   fsm_h2l;
  logic                   fsm_l2h;

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Stages reset to the idle level so a reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{KEY_IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_pin};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_HIGH;
      cnt     <= '0;
      fsm_h2l <= 1'b0;
      fsm_l2h <= 1'b0;
    end else begin
      fsm_h2l <= 1'b0;
      fsm_l2h <= 1'b0;
      case (state)
        ST_HIGH: begin
          if (!sync_in) begin
            state <= ST_FALL;
            cnt   <= CNT_W'(1);
          end
        end
        ST_FALL: begin
          // A return to the old level throws away the whole candidate window.
          if (sync_in) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_LOW;
            cnt     <= '0;
            fsm_h2l <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LOW: begin
          if (sync_in) begin
            state <= ST_RISE;
            cnt   <= CNT_W'(1);
          end
        end
        ST_RISE: begin
          if (!sync_in) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_HIGH;
            cnt     <= '0;
            fsm_l2h <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_HIGH;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_state <= KEY_IDLE_LEVEL;
      h2l_edge  <= 1'b0;
      l2h_edge  <= 1'b0;
    end else begin
      key_state <= (state == ST_HIGH) || (state == ST_FALL);
      h2l_edge  <= fsm_h2l;
      l2h_edge  <= fsm_l2h;
    end
  end

`ifdef ZKEY_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic              fsm_long;

  // Bouncing between LOW and RISE keeps the hold time; saturating stops repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      fsm_long <= 1'b0;
    end else begin
      fsm_long <= 1'b0;
      if (state == ST_LOW || state == ST_RISE) begin
        if (hold_cnt == HOLD_LAST) begin
          fsm_long <= 1'b1;
        end
        if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_press <= 1'b0;
    end else begin
      long_press <= fsm_long;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/zkey_multi_debounce_edge.sv
// CHANNELS independent debounced active-low keys with press/release pulses.
// Define ZKEY_LONG_PRESS_EN to enable per-channel long-press pulses.
module zkey_multi_debounce_edge
  import zkey_pkg::*;
#(
  parameter int CHANNELS          = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 20000,
  parameter int LONG_PRESS_CYCLES = 2000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key_pin,
  output logic [CHANNELS-1:0] key_state,
  output logic [CHANNELS-1:0] h2l_edge,
  output logic [CHANNELS-1:0] l2h_edge,
  output logic [CHANNELS-1:0] long_press
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("zkey_multi_debounce_edge: CHANNELS out of range");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    zkey_debounce_chan #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .key_pin   (key_pin[i]),
      .key_state (key_state[i]),
      .h2l_edge  (h2l_edge[i]),
      .l2h_edge  (l2h_edge[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_zkey_multi_debounce_edge.sv
// Scoreboard bench for zkey_multi_debounce_edge: expected pulses are queued with
// their due cycle when keys are driven, then compared against outputs every cycle.
module tb_zkey_multi_debounce_edge;

  localparam int CHANNELS = 4;
  localparam int SYNC     = 2;
  localparam int DEB      = 8;
  localparam int LONG     = 32;
  localparam int LAT      = 1 + SYNC + DEB;

  localparam int K_H2L  = 0;
  localparam int K_L2H  = 1;
  localparam int K_LONG = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } sb_entry_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CHANNELS-1:0] key_pin = '1;
  logic [CHANNELS-1:0] key_state;
  logic [CHANNELS-1:0] h2l_edge;
  logic [CHANNELS-1:0] l2h_edge;
  logic [CHANNELS-1:0] long_press;

  sb_entry_t           scoreboard[$];
  int                  cyc = 0;
  bit                  mon_on = 1'b0;
  int                  vec_count = 0;
  int                  miss_count = 0;
  logic [CHANNELS-1:0] exp_state;
  logic [CHANNELS-1:0] exp_h2l;
  logic [CHANNELS-1:0] exp_l2h;
  logic [CHANNELS-1:0] exp_long;

  zkey_multi_debounce_edge #(
    .CHANNELS         (CHANNELS),
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pin   (key_pin),
    .key_state (key_state),
    .h2l_edge  (h2l_edge),
    .l2h_edge  (l2h_edge),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
    end
  endtask

  // Called at a negedge; holds the pin pattern for the given number of cycles.
  task automatic applyStimulus(input logic [CHANNELS-1:0] pins, input int cycles);
    key_pin = pins;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expectEdge(input int kind, input int ch, input int due);
    sb_entry_t e;
    e.cyc  = due;
    e.kind = kind;
    e.ch   = ch;
    scoreboard.push_back(e);
  endtask

  // Pop everything due this cycle and compare all outputs against it.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      exp_h2l  = '0;
      exp_l2h  = '0;
      exp_long = '0;
      for (int i = scoreboard.size() - 1; i >= 0; i--) begin
        if (scoreboard[i].cyc == cyc) begin
          case (scoreboard[i].kind)
            K_H2L:   exp_h2l[scoreboard[i].ch]  = 1'b1;
            K_L2H:   exp_l2h[scoreboard[i].ch]  = 1'b1;
            default: exp_long[scoreboard[i].ch] = 1'b1;
          endcase
          scoreboard.delete(i);
        end
      end
      exp_state = (exp_state & ~exp_h2l) | exp_l2h;
      checkOutput("h2l_edge", 32'(h2l_edge), 32'(exp_h2l));
      checkOutput("l2h_edge", 32'(l2h_edge), 32'(exp_l2h));
      checkOutput("long_press", 32'(long_press), 32'(exp_long));
      checkOutput("key_state", 32'(key_state), 32'(exp_state));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    exp_state = '1;
    mon_on    = 1'b1;
    $display("[TB] reset released, idle check");
    applyStimulus(4'hF, 20);

    $display("[TB] clean press and release on ch0");
    expectEdge(K_H2L, 0, cyc + LAT);
    applyStimulus(4'hE, 20);
    expectEdge(K_L2H, 0, cyc + LAT);
    applyStimulus(4'hF, 20);

    $display("[TB] bounce on ch1");
    applyStimulus(4'hD, 5);
    applyStimulus(4'hF, 1);
    applyStimulus(4'hD, 3);
    applyStimulus(4'hF, 15);
    expectEdge(K_H2L, 1, cyc + LAT);
    applyStimulus(4'hD, 15);
    expectEdge(K_L2H, 1, cyc + LAT);
    applyStimulus(4'hF, 15);

    $display("[TB] simultaneous press on ch2 and ch3");
    expectEdge(K_H2L, 2, cyc + LAT);
    expectEdge(K_H2L, 3, cyc + LAT);
    applyStimulus(4'h3, 15);
    expectEdge(K_L2H, 2, cyc + LAT);
    expectEdge(K_L2H, 3, cyc + LAT);
    applyStimulus(4'hF, 15);

    $display("[TB] reset during ch0 debounce");
    applyStimulus(4'hE, 4);
    rst = 1'b1;
    scoreboard.delete();
    exp_state = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expectEdge(K_H2L, 0, cyc + LAT);
    applyStimulus(4'hE, 15);
    expectEdge(K_L2H, 0, cyc + LAT);
    applyStimulus(4'hF, 15);

    $display("[TB] long hold on ch0");
    expectEdge(K_H2L, 0, cyc + LAT);
`ifdef ZKEY_LONG_PRESS_EN
    expectEdge(K_LONG, 0, cyc + LAT + LONG);
`endif
    applyStimulus(4'hE, 60);
    expectEdge(K_L2H, 0, cyc + LAT);
    applyStimulus(4'hF, 20);

    mon_on = 1'b0;
    checkOutput("sb_empty", 32'(scoreboard.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
